calc_alu_engine: RTL and testbench
==================================

Name: calc_alu_engine

Overview:
- Arithmetic back end of the hardware calculator.
- Consumes operands a, b and the operator code captured by the PS/2 keypad front end, computes the result, and drives result plus completion and error status.
- Its outputs feed the 7-segment display path and the Avalon register slave (r and status).
- Add and subtract are single-cycle; multiply, divide and modulo are iterative shift-add or restoring-division engines.

Parameters:
- WIDTH, 16, operand and result width in bits; also the number of iterations for MUL/DIV/MOD.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- op_code  input  16  operator; only bits [2:0] are decoded, bits [15:3] are ignored
- start  input  1  one-cycle request; sampled only when busy=0
- result  output  WIDTH  registered result
- done  output  1  level; high from completion until the next accepted start
- busy  output  1  high while an operation is in progress
- ovf  output  1  carry/borrow/product overflow for the last operation
- div0  output  1  last DIV/MOD had b==0
- bad_op  output  1  last op_code[2:0] was not a defined operator

Behaviour:
- Reset, synchronous and checked first each edge:
  - result=0, done=0, busy=0, ovf=0, div0=0, bad_op=0.
  - FSM goes to IDLE; the iteration counter and internal shift registers are cleared.
  - Reset during an operation aborts it; no done is produced.
- Op encoding (op_code[2:0]): 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101-111 invalid.
- FSM states: IDLE, ITER, FIN.
- Accept: if start=1 in cycle N with busy=0 (IDLE or FIN):
  - a, b and op_code[2:0] are latched.
  - done, ovf, div0 and bad_op are cleared.
  - Later changes on a, b or op_code do not affect the operation in flight.
- Single-cycle path (ADD, SUB, invalid op, DIV/MOD with b==0):
  - At the edge ending cycle N the FSM goes to FIN.
  - result and flags are valid and done=1 from cycle N+1.
  - busy stays 0 throughout.
- Iterative path (MUL, DIV/MOD with b!=0):
  - At the edge ending cycle N the FSM goes to ITER; busy=1 from N+1.
  - ITER runs WIDTH iterations, one per cycle, counter 0..WIDTH-1.
  - On the last iteration the FSM goes to FIN: done=1 and busy=0 from cycle N+WIDTH+1 (N+17 at default width).
- Arithmetic, all unsigned:
  - ADD: result = (a+b) mod 2^WIDTH; ovf = carry out.
  - SUB: result = (a-b) mod 2^WIDTH (wraps); ovf=1 iff a<b.
  - MUL: 2*WIDTH-bit shift-add product; result = low WIDTH bits; ovf=1 iff the high WIDTH bits are nonzero.
  - DIV: restoring division; result = floor(a/b); ovf=0.
  - MOD: result = a mod b; ovf=0.
  - DIV/MOD with b==0: result={WIDTH{1}}, div0=1, no iteration.
  - Invalid op: result=0, bad_op=1.
- FIN:
  - Holds result and flags stable indefinitely.
  - start=1 in FIN is accepted exactly as in IDLE, so done drops the cycle after acceptance.
- start while busy=1 is ignored; no queuing and no effect on the running operation.
- start and rst in the same cycle: rst wins.
- result must not change at any point between acceptance and completion except at the completion edge (intermediate values are held in internal registers).

Test Plan:
- Reset: hold rst 2 cycles mid-MUL (a=300, b=300) -> all outputs 0 the cycle after release; done never rises for the aborted op.
- ADD/SUB:
  - a=0xFFFF, b=0x0002, op=000, start at N -> result=0x0001, ovf=1, done=1 at N+1, busy never 1.
  - op=001, a=5, b=7 -> result=0xFFFE, ovf=1.
- MUL:
  - a=300, b=200, op=010 -> busy N+1..N+16; result=0xEA60 (60000), ovf=0, done at N+17.
  - a=0x1000, b=0x0010 -> result=0x0000, ovf=1.
- DIV/MOD:
  - a=1000, b=7: op=011 -> result=142; op=100 -> result=6, each done at N+17.
  - b=0, op=011 -> result=0xFFFF, div0=1, done at N+1.
- Busy handling: start pulsed again at N+5 during MUL with different operands -> ignored; the original product is delivered at N+17. Operand inputs changed mid-op -> result unaffected.
- Invalid op and restart: op=110 -> bad_op=1, result=0, done at N+1. Then start ADD 2+3 while in FIN -> done low for one cycle, then result=5, bad_op=0.

Source files
------------

// File: rtl/calc_alu_engine.sv
// Arithmetic back end of the calculator: single-cycle ADD/SUB, WIDTH-iteration
// shift-add multiply and restoring divide/modulo, with registered result and status.
module calc_alu_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [15:0]      op_code,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic             div0,
  output logic             bad_op,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d, ovf_q, ovf_d, div0_q, div0_d, bad_q, bad_d;

  logic [2:0]       op_in;
  logic             accept, is_iter;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf, sc_div0, sc_bad;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] nxt_acc, nxt_sh;
  logic             unused_op_bits;

  assign op_in          = op_code[2:0];
  assign unused_op_bits = ^op_code[15:3];
  assign accept         = start && (state_q != ITER);
  assign is_iter        = (op_in == OP_MUL) ||
                          (((op_in == OP_DIV) || (op_in == OP_MOD)) && (b != '0));
  assign add_w          = {1'b0, a} + {1'b0, b};
  assign sub_w          = {1'b0, a} - {1'b0, b};

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_div0   = 1'b0;
    sc_bad    = 1'b0;
    case (op_in)
      OP_ADD: begin sc_result = add_w[WIDTH-1:0]; sc_ovf = add_w[WIDTH]; end
      OP_SUB: begin sc_result = sub_w[WIDTH-1:0]; sc_ovf = sub_w[WIDTH]; end
      OP_MUL: ;
      OP_DIV, OP_MOD: begin sc_result = '1; sc_div0 = 1'b1; end
      default: sc_bad = 1'b1;
    endcase
  end

  // MUL: {acc,sh} is the product register with the multiplier in sh.
  // DIV/MOD: acc is the partial remainder, sh shifts dividend out and quotient in.
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
  assign div_sh   = {acc_q, sh_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    nxt_acc = acc_q;
    nxt_sh  = sh_q;
    if (op_q == OP_MUL) begin
      nxt_acc = mul_sum[WIDTH:1];
      nxt_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      nxt_acc = div_diff[WIDTH-1:0];
      nxt_sh  = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      nxt_acc = div_sh[WIDTH-1:0];
      nxt_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;
    bad_d    = bad_q;
    case (state_q)
      ITER: begin
        acc_d = nxt_acc;
        sh_d  = nxt_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = FIN;
          done_d   = 1'b1;
          result_d = (op_q == OP_MOD) ? nxt_acc : nxt_sh;
          ovf_d    = (op_q == OP_MUL) && (nxt_acc != '0);
        end
      end
      // A restart from FIN leaves done low for one cycle before it rises again.
      FIN: if (!done_q) done_d = 1'b1;
      default: ;
    endcase
    if (accept) begin
      a_d    = a;
      b_d    = b;
      op_d   = op_in;
      ovf_d  = 1'b0;
      div0_d = 1'b0;
      bad_d  = 1'b0;
      done_d = 1'b0;
      if (is_iter) begin
        state_d = ITER;
        cnt_d   = '0;
        acc_d   = '0;
        sh_d    = (op_in == OP_MUL) ? b : a;
      end else begin
        state_d  = FIN;
        result_d = sc_result;
        ovf_d    = sc_ovf;
        div0_d   = sc_div0;
        bad_d    = sc_bad;
        done_d   = (state_q == IDLE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
      bad_q    <= bad_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q == ITER);
  assign ovf       = ovf_q;
  assign div0      = div0_q;
  assign bad_op    = bad_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_alu_engine.sv
// Directed bench for calc_alu_engine: hand-computed vectors for every operator,
// latency, busy handling, restart from FIN and reset abort.
module tb_calc_alu_engine;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [15:0]  op_code;
  logic         start;
  logic [W-1:0] result;
  logic         done, busy, ovf, div0, bad_op;
  logic [1:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  calc_alu_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op_code(op_code), .start(start),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .div0(div0),
    .bad_op(bad_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives start for cycle N; returns in cycle N+1.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [15:0] op);
    a = av; b = bv; op_code = op; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_result"}, 32'(result), 32'h0);
    chk({tag, "_done"},   32'(done),   32'h0);
    chk({tag, "_busy"},   32'(busy),   32'h0);
    chk({tag, "_ovf"},    32'(ovf),    32'h0);
    chk({tag, "_div0"},   32'(div0),   32'h0);
    chk({tag, "_bad_op"}, 32'(bad_op), 32'h0);
  endtask

  // Iterative op: busy N+1..N+16 with result held, completion at N+17.
  task automatic run_iter(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [15:0] op, input logic [W-1:0] exp_res, input logic exp_ovf);
    logic [W-1:0] held;
    int bad_busy;
    held = result;
    bad_busy = 0;
    issue(av, bv, op);
    for (int k = 1; k <= 16; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || result !== held) bad_busy++;
      step();
    end
    chk({tag, "_busy_window"}, 32'(bad_busy), 32'h0);
    chk({tag, "_done"},   32'(done),   32'h1);
    chk({tag, "_busy"},   32'(busy),   32'h0);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_ovf"},    32'(ovf),    32'(exp_ovf));
    chk({tag, "_div0"},   32'(div0),   32'h0);
  endtask

  initial begin
    logic [W-1:0] held;
    int saw_done;
    rst = 1'b1; a = '0; b = '0; op_code = '0; start = 1'b0;
    step(); step();
    rst = 1'b0;
    check_idle_outputs("reset");
    chk("reset_state", 32'(state_dbg), 32'h0);

    // ADD with carry out
    issue(16'hFFFF, 16'h0002, 16'h0000);
    chk("add_result", 32'(result), 32'h0001);
    chk("add_ovf",    32'(ovf),    32'h1);
    chk("add_done",   32'(done),   32'h1);
    chk("add_busy",   32'(busy),   32'h0);

    // SUB with borrow, restarted from FIN
    issue(16'd5, 16'd7, 16'h0001);
    chk("sub_done_gap", 32'(done), 32'h0);
    chk("sub_result",   32'(result), 32'hFFFE);
    chk("sub_ovf",      32'(ovf),    32'h1);
    step();
    chk("sub_done",     32'(done),   32'h1);

    // MUL 300*200 with a second start at N+5 and operand changes mid-op
    held = result;
    issue(16'd300, 16'd200, 16'h0002);
    saw_done = 0;
    for (int k = 1; k <= 16; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || result !== held) saw_done++;
      if (k == 5) begin a = 16'd9; b = 16'd9; op_code = 16'h0000; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (k == 8) begin a = 16'h1234; b = 16'h0; op_code = 16'h0003; end
      step();
    end
    chk("mul_busy_window", 32'(saw_done), 32'h0);
    chk("mul_done",   32'(done),   32'h1);
    chk("mul_busy",   32'(busy),   32'h0);
    chk("mul_result", 32'(result), 32'hEA60);
    chk("mul_ovf",    32'(ovf),    32'h0);

    run_iter("mul_ovf",  16'h1000, 16'h0010, 16'h0002, 16'h0000, 1'b1);
    run_iter("div",      16'd1000, 16'd7,    16'h0003, 16'd142,  1'b0);
    run_iter("mod",      16'd1000, 16'd7,    16'h0004, 16'd6,    1'b0);
    run_iter("div_max",  16'hFFFF, 16'h0001, 16'h0003, 16'hFFFF, 1'b0);
    run_iter("mul_hi",   16'hFFFF, 16'hFFFF, 16'h0002, 16'h0001, 1'b1);

    // DIV by zero: single cycle; from FIN so done shows the one-cycle gap
    issue(16'd1000, 16'd0, 16'h0003);
    chk("div0_busy",   32'(busy),   32'h0);
    chk("div0_result", 32'(result), 32'hFFFF);
    chk("div0_flag",   32'(div0),   32'h1);
    step();
    chk("div0_done",   32'(done),   32'h1);

    // Invalid op, then ADD 2+3 with upper op_code bits set
    issue(16'd4, 16'd4, 16'h0006);
    chk("bad_result", 32'(result), 32'h0);
    chk("bad_flag",   32'(bad_op), 32'h1);
    chk("bad_div0",   32'(div0),   32'h0);
    step();
    chk("bad_done",   32'(done),   32'h1);
    issue(16'd2, 16'd3, 16'hA000);
    chk("restart_done_low", 32'(done), 32'h0);
    step();
    chk("restart_done",   32'(done),   32'h1);
    chk("restart_result", 32'(result), 32'h5);
    chk("restart_bad_op", 32'(bad_op), 32'h0);
    chk("restart_ovf",    32'(ovf),    32'h0);

    // Reset in the middle of MUL 300*300 aborts without done
    issue(16'd300, 16'd300, 16'h0002);
    step(); step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_idle_outputs("abort");
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
      step();
    end
    chk("abort_no_done", 32'(saw_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
